// File: rtl/eda_frame_sequencer_pkg.sv
// Shared geometry defaults and FSM state encoding for the frame sequencer.
// Geometry macros take their default here unless a global define set them first.
`ifndef CFG_M
`define CFG_M 4
`endif
`ifndef CFG_N
`define CFG_N 4
`endif
`ifndef CFG_PIXEL_WIDTH
`define CFG_PIXEL_WIDTH 8
`endif
`ifndef CFG_ADDR_WIDTH
`define CFG_ADDR_WIDTH 8
`endif
`ifndef CFG_I_WIDTH
`define CFG_I_WIDTH 4
`endif
`ifndef CFG_J_WIDTH
`define CFG_J_WIDTH 4
`endif

package eda_regional_max_pkg;

    localparam int FRAME_PIXELS = `CFG_M * `CFG_N;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_GAP  = 3'd2,
        ST_KICK = 3'd3,
        ST_WAIT = 3'd4,
        ST_HOLD = 3'd5
    } seq_state_e;

endpackage

// File: rtl/eda_frame_sequencer_if.sv
// Bundle of pixel stream, core-side and result-side signals of the frame sequencer.
// The master view belongs to the sequencer; the slave view to its surroundings.
interface eda_frame_sequencer_if
    import eda_regional_max_pkg::*;
#(
    parameter int PIXEL_WIDTH = `CFG_PIXEL_WIDTH,
    parameter int ADDR_WIDTH  = `CFG_ADDR_WIDTH,
    parameter int MATRIX_BITS = FRAME_PIXELS
);

    logic [PIXEL_WIDTH-1:0] s_pixel;
    logic                   s_valid;
    logic                   s_ready;
    logic                   s_last;

    logic [PIXEL_WIDTH-1:0] m_pixel;
    logic [ADDR_WIDTH-1:0]  m_wr_addr;
    logic                   m_write_en;
    logic                   m_start;
    logic                   m_done;
    logic [MATRIX_BITS-1:0] m_matrix;

    logic [MATRIX_BITS-1:0] res_matrix;
    logic                   res_valid;
    logic                   res_ready;
    logic                   frame_err;
    logic                   timeout;
    logic [15:0]            frame_cnt;

    modport master (
        input  s_pixel, s_valid, s_last, m_done, m_matrix, res_ready,
        output s_ready, m_pixel, m_wr_addr, m_write_en, m_start,
               res_matrix, res_valid, frame_err, timeout, frame_cnt
    );

    modport slave (
        output s_pixel, s_valid, s_last, m_done, m_matrix, res_ready,
        input  s_ready, m_pixel, m_wr_addr, m_write_en, m_start,
               res_matrix, res_valid, frame_err, timeout, frame_cnt
    );

endinterface

// File: rtl/eda_frame_sequencer_addr_gen.sv
// Row-major {i,j} pixel index counter; wraps to (0,0) after (M-1,N-1).
module eda_seq_addr_gen #(
    parameter int M       = 4,
    parameter int N       = 4,
    parameter int I_WIDTH = 4,
    parameter int J_WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               inc,
    input  logic               clr,
    output logic [I_WIDTH-1:0] i,
    output logic [J_WIDTH-1:0] j,
    output logic               last
);

    localparam logic [I_WIDTH-1:0] I_LAST = I_WIDTH'(M - 1);
    localparam logic [J_WIDTH-1:0] J_LAST = J_WIDTH'(N - 1);

    logic [I_WIDTH-1:0] i_r;
    logic [J_WIDTH-1:0] j_r;

    assign i    = i_r;
    assign j    = j_r;
    assign last = (i_r == I_LAST) && (j_r == J_LAST);

    // Index advance: column first, row on column wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i_r <= {I_WIDTH{1'b0}};
            j_r <= {J_WIDTH{1'b0}};
        end else if (inc) begin
            if (j_r == J_LAST) begin
                j_r <= {J_WIDTH{1'b0}};
                i_r <= (i_r == I_LAST) ? {I_WIDTH{1'b0}} : i_r + I_WIDTH'(1);
            end else begin
                j_r <= j_r + J_WIDTH'(1);
            end
        end else if (clr) begin
            i_r <= {I_WIDTH{1'b0}};
            j_r <= {J_WIDTH{1'b0}};
        end
    end

endmodule

// File: rtl/eda_frame_sequencer.sv
// Streams one M x N frame into the regional-max core, kicks it, waits for done
// and holds the captured result matrix until the consumer takes it.
module eda_frame_sequencer
    import eda_regional_max_pkg::*;
#(
    parameter int M              = `CFG_M,
    parameter int N              = `CFG_N,
    parameter int PIXEL_WIDTH    = `CFG_PIXEL_WIDTH,
    parameter int ADDR_WIDTH     = `CFG_ADDR_WIDTH,
    parameter int I_WIDTH        = `CFG_I_WIDTH,
    parameter int J_WIDTH        = `CFG_J_WIDTH,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  reset_n,
    eda_frame_sequencer_if.master bus
);

    localparam logic [2:0] IDLE = 3'(ST_IDLE);
    localparam logic [2:0] LOAD = 3'(ST_LOAD);
    localparam logic [2:0] GAP  = 3'(ST_GAP);
    localparam logic [2:0] KICK = 3'(ST_KICK);
    localparam logic [2:0] WAIT = 3'(ST_WAIT);
    localparam logic [2:0] HOLD = 3'(ST_HOLD);

    localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]             state_r;
    logic [2:0]             state_s;
    logic [1:0]             gap_cnt_r;
    logic [TW-1:0]          wait_cnt_r;
    logic                   s_ready_r;
    logic                   m_write_en_r;
    logic                   m_start_r;
    logic                   m_done_q_r;
    logic                   res_valid_r;
    logic                   frame_err_r;
    logic                   timeout_r;
    logic [PIXEL_WIDTH-1:0] m_pixel_r;
    logic [ADDR_WIDTH-1:0]  m_wr_addr_r;
    logic [M*N-1:0]         res_matrix_r;
    logic [15:0]            frame_cnt_r;

    logic [I_WIDTH-1:0]     i_s;
    logic [J_WIDTH-1:0]     j_s;
    logic                   last_s;
    logic                   beat_s;
    logic                   mismatch_s;
    logic                   done_rise_s;
    logic                   res_take_s;
    logic                   addr_clr_s;

    assign beat_s      = bus.s_valid & s_ready_r;
    assign mismatch_s  = bus.s_last ^ last_s;
    assign done_rise_s = (state_r == WAIT) & bus.m_done & ~m_done_q_r;
    assign res_take_s  = (state_r == HOLD) & res_valid_r & bus.res_ready;
    assign addr_clr_s  = ~s_ready_r;

    eda_seq_addr_gen #(
        .M       (M),
        .N       (N),
        .I_WIDTH (I_WIDTH),
        .J_WIDTH (J_WIDTH)
    ) u_addr_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (beat_s),
        .clr     (addr_clr_s),
        .i       (i_s),
        .j       (j_s),
        .last    (last_s)
    );

    // Next-state decode; the frame closes on the pixel count alone, never on s_last.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (beat_s) begin
                    state_s = last_s ? GAP : LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                if (beat_s && last_s) begin
                    state_s = GAP;
                end else begin
                    state_s = LOAD;
                end
            end
            GAP: begin
                if (gap_cnt_r == 2'd2) begin
                    state_s = KICK;
                end else begin
                    state_s = GAP;
                end
            end
            KICK: begin
                state_s = WAIT;
            end
            WAIT: begin
                if (done_rise_s) begin
                    state_s = HOLD;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT;
                end
            end
            HOLD: begin
                if (res_take_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register plus the GAP and WAIT cycle counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            gap_cnt_r  <= 2'd0;
            wait_cnt_r <= {TW{1'b0}};
        end else begin
            state_r    <= state_s;
            gap_cnt_r  <= (state_r == GAP) ? gap_cnt_r + 2'd1 : 2'd0;
            wait_cnt_r <= (state_r == WAIT) ? wait_cnt_r + TW'(1) : {TW{1'b0}};
        end
    end

    // Stream-side ready and the one-cycle-delayed core write port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_ready_r    <= 1'b0;
            m_write_en_r <= 1'b0;
            m_pixel_r    <= {PIXEL_WIDTH{1'b0}};
            m_wr_addr_r  <= {ADDR_WIDTH{1'b0}};
            m_start_r    <= 1'b0;
            m_done_q_r   <= 1'b0;
        end else begin
            s_ready_r    <= (state_s == IDLE) || (state_s == LOAD);
            m_write_en_r <= beat_s;
            if (beat_s) begin
                m_pixel_r   <= bus.s_pixel;
                m_wr_addr_r <= ADDR_WIDTH'({i_s, j_s});
            end
            m_start_r    <= (state_s == KICK);
            m_done_q_r   <= bus.m_done;
        end
    end

    // Result capture, handshake, frame counter and sticky status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_matrix_r <= {(M*N){1'b0}};
            res_valid_r  <= 1'b0;
            frame_cnt_r  <= 16'd0;
            frame_err_r  <= 1'b0;
            timeout_r    <= 1'b0;
        end else begin
            if (done_rise_s) begin
                res_matrix_r <= bus.m_matrix;
            end
            res_valid_r <= (state_s == HOLD);
            if (res_take_s) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end
            // The first beat of a frame restarts both sticky flags.
            if (beat_s) begin
                frame_err_r <= (state_r == IDLE) ? mismatch_s : (frame_err_r | mismatch_s);
            end
            if (beat_s && (state_r == IDLE)) begin
                timeout_r <= 1'b0;
            end else if ((state_r == WAIT) && (state_s == IDLE)) begin
                timeout_r <= 1'b1;
            end
        end
    end

    assign bus.s_ready    = s_ready_r;
    assign bus.m_pixel    = m_pixel_r;
    assign bus.m_wr_addr  = m_wr_addr_r;
    assign bus.m_write_en = m_write_en_r;
    assign bus.m_start    = m_start_r;
    assign bus.res_matrix = res_matrix_r;
    assign bus.res_valid  = res_valid_r;
    assign bus.frame_err  = frame_err_r;
    assign bus.timeout    = timeout_r;
    assign bus.frame_cnt  = frame_cnt_r;

endmodule

// File: tb/tb_eda_frame_sequencer.sv
// Directed bench for eda_frame_sequencer with M=N=4, 8-bit pixels and a small
// core model whose result bit k is the LSB of the pixel written at {k/4,k%4}.
module tb_eda_frame_sequencer;

    localparam int M  = 4;
    localparam int N  = 4;
    localparam int PW = 8;
    localparam int AW = 8;
    localparam int IW = 4;
    localparam int JW = 4;
    localparam int TO = 20;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    eda_frame_sequencer_if #(
        .PIXEL_WIDTH (PW),
        .ADDR_WIDTH  (AW),
        .MATRIX_BITS (M*N)
    ) bus ();

    eda_frame_sequencer #(
        .M              (M),
        .N              (N),
        .PIXEL_WIDTH    (PW),
        .ADDR_WIDTH     (AW),
        .I_WIDTH        (IW),
        .J_WIDTH        (JW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Core model: pixel memory and a log of every write address in order.
    logic [7:0] mem      [256];
    logic [7:0] addr_log [128];
    int         wr_cnt = 0;

    always @(posedge clk) begin
        if (bus.m_write_en === 1'b1) begin
            mem[bus.m_wr_addr]       <= bus.m_pixel;
            addr_log[7'(wr_cnt)]     <= bus.m_wr_addr;
            wr_cnt                   <= wr_cnt + 1;
        end
    end

    int   n_checks = 0;
    int   n_fail   = 0;
    int   wr_start;
    logic err_after_first;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] model_matrix();
        logic [15:0] r;
        for (int k = 0; k < 16; k++) begin
            r[k] = mem[{4'(k / 4), 4'(k % 4)}][0];
        end
        return r;
    endfunction

    // Streams n_beats pixels base + b*stride back to back; s_last on beat index last_beat.
    task automatic send_frame(input logic [7:0] base, input logic [7:0] stride,
                              input int last_beat, input int n_beats);
        for (int b = 0; b < n_beats; b++) begin
            bus.s_pixel = base + 8'(b) * stride;
            bus.s_valid = 1'b1;
            bus.s_last  = (b == last_beat);
            chk("s_ready_on_beat", 32'(bus.s_ready), 32'd1);
            step(1);
            if (b == 0) err_after_first = bus.frame_err;
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic check_writes(input int first);
        chk("write_count", 32'(wr_cnt - first), 32'd16);
        for (int k = 0; k < 16; k++) begin
            chk("wr_addr_order", 32'(addr_log[7'(first + k)]), 32'({4'(k / 4), 4'(k % 4)}));
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.s_pixel   = 8'h00;
        bus.s_valid   = 1'b0;
        bus.s_last    = 1'b0;
        bus.m_done    = 1'b0;
        bus.m_matrix  = 16'h0000;
        bus.res_ready = 1'b0;
        step(2);

        chk("rst_s_ready",    32'(bus.s_ready),    32'd0);
        chk("rst_write_en",   32'(bus.m_write_en), 32'd0);
        chk("rst_start",      32'(bus.m_start),    32'd0);
        chk("rst_res_valid",  32'(bus.res_valid),  32'd0);
        chk("rst_frame_err",  32'(bus.frame_err),  32'd0);
        chk("rst_timeout",    32'(bus.timeout),    32'd0);
        chk("rst_frame_cnt",  32'(bus.frame_cnt),  32'd0);
        chk("rst_res_matrix", 32'(bus.res_matrix), 32'd0);

        reset_n = 1'b1;
        step(1);
        chk("release_s_ready", 32'(bus.s_ready), 32'd1);

        // Frame 1: pixels 0x00..0x0F, correct s_last, done level high before WAIT.
        wr_start = wr_cnt;
        send_frame(8'h00, 8'h01, 15, 16);
        chk("f1_write_en_T", 32'(bus.m_write_en), 32'd1);
        chk("f1_start_T",    32'(bus.m_start),    32'd0);
        chk("f1_ready_gap",  32'(bus.s_ready),    32'd0);
        bus.m_done = 1'b1;
        for (int d = 1; d <= 4; d++) begin
            step(1);
            chk("f1_start_pulse", 32'(bus.m_start), 32'(d == 3));
            chk("f1_write_en_off", 32'(bus.m_write_en), 32'd0);
        end
        chk("f1_frame_err", 32'(bus.frame_err), 32'd0);
        check_writes(wr_start);
        chk("f1_pixels", 32'(model_matrix()), 32'h0000AAAA);
        step(3);
        chk("f1_level_ignored", 32'(bus.res_valid), 32'd0);
        bus.m_done = 1'b0;
        step(1);
        chk("f1_no_capture", 32'(bus.res_valid), 32'd0);
        bus.m_matrix = model_matrix();
        bus.m_done   = 1'b1;
        step(1);
        chk("f1_res_valid",  32'(bus.res_valid),  32'd1);
        chk("f1_res_matrix", 32'(bus.res_matrix), 32'h0000AAAA);
        bus.m_matrix = 16'h1234;
        bus.m_done   = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step(1);
            chk("hold_valid",  32'(bus.res_valid),  32'd1);
            chk("hold_matrix", 32'(bus.res_matrix), 32'h0000AAAA);
        end
        chk("hold_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        bus.res_ready = 1'b1;
        step(1);
        bus.res_ready = 1'b0;
        chk("f1_valid_drop", 32'(bus.res_valid), 32'd0);
        chk("f1_frame_cnt",  32'(bus.frame_cnt), 32'd1);
        chk("f1_idle_ready", 32'(bus.s_ready),   32'd1);

        // Frame 2: early s_last on beat 5, res_ready held high from the start.
        wr_start      = wr_cnt;
        bus.res_ready = 1'b1;
        send_frame(8'h21, 8'h02, 4, 16);
        chk("f2_frame_err", 32'(bus.frame_err), 32'd1);
        step(4);
        chk("f2_ready_no_effect", 32'(bus.frame_cnt), 32'd1);
        chk("f2_write_count", 32'(wr_cnt - wr_start), 32'd16);
        chk("f2_pixels", 32'(model_matrix()), 32'h0000FFFF);
        bus.m_matrix = model_matrix();
        bus.m_done   = 1'b1;
        step(1);
        chk("f2_res_valid",  32'(bus.res_valid),  32'd1);
        chk("f2_res_matrix", 32'(bus.res_matrix), 32'h0000FFFF);
        step(1);
        chk("f2_first_hold_take", 32'(bus.res_valid), 32'd0);
        chk("f2_frame_cnt",       32'(bus.frame_cnt), 32'd2);
        bus.res_ready = 1'b0;
        bus.m_done    = 1'b0;

        // Frame 3: core never answers, so the WAIT counter expires.
        send_frame(8'h00, 8'h01, 15, 16);
        chk("f3_err_cleared_first", 32'(err_after_first), 32'd0);
        chk("f3_frame_err", 32'(bus.frame_err), 32'd0);
        step(23);
        chk("f3_timeout_pending", 32'(bus.timeout), 32'd0);
        chk("f3_still_wait",      32'(bus.s_ready), 32'd0);
        step(1);
        chk("f3_timeout",   32'(bus.timeout),   32'd1);
        chk("f3_idle",      32'(bus.s_ready),   32'd1);
        chk("f3_res_valid", 32'(bus.res_valid), 32'd0);
        chk("f3_frame_cnt", 32'(bus.frame_cnt), 32'd2);

        // Frame 4: reset after beat 7 discards the partial frame.
        send_frame(8'h80, 8'h01, 99, 7);
        chk("f4_timeout_cleared", 32'(bus.timeout),    32'd0);
        chk("f4_write_en_pre",    32'(bus.m_write_en), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("f4_rst_write_en",   32'(bus.m_write_en), 32'd0);
        chk("f4_rst_wr_addr",    32'(bus.m_wr_addr),  32'd0);
        chk("f4_rst_pixel",      32'(bus.m_pixel),    32'd0);
        chk("f4_rst_s_ready",    32'(bus.s_ready),    32'd0);
        chk("f4_rst_frame_cnt",  32'(bus.frame_cnt),  32'd0);
        chk("f4_rst_res_matrix", 32'(bus.res_matrix), 32'd0);
        step(2);
        reset_n = 1'b1;
        step(1);
        chk("f4_release_ready", 32'(bus.s_ready), 32'd1);

        // Frame 5: a fresh frame must start again at address 0x00.
        wr_start = wr_cnt;
        send_frame(8'h00, 8'h01, 15, 16);
        chk("f5_frame_err", 32'(bus.frame_err), 32'd0);
        step(1);
        check_writes(wr_start);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
